instr_fetch_unit: RTL and testbench

Sequential fetch stage for the single-cycle processor when its instruction memory is moved behind a request/acknowledge port. It holds the byte-addressed PC, converts it to the word index the memory expects (byte address >> 2), and presents each fetched word with its PC under a valid/stall handshake. It is the consumer of byte-scaled branch and jump targets produced upstream. It redirects on those targets and traps on any that are not word-aligned.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/instr_fetch_unit_pc_reg.sv | 34 +++
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 tb/tb_instr_fetch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage: FSM states,
// word size and the redirect-target alignment check.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  function automatic logic is_word_aligned(input logic [31:0] target);
    return (target[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Byte-addressed program counter: loads either the sequential successor or
// a redirect target when enabled, otherwise holds.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic        load_redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc
);

  logic [31:0] next_pc;

  // Sequential successor wraps naturally at the top of the address space.
  always_comb begin
    next_pc = pc + WORD_BYTES;
    if (load_redirect) begin
      next_pc = redirect_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential fetch stage: drives a request/ack instruction memory from the
// PC, presents each word with its PC, redirects and traps misaligned targets.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_word_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               instr_valid,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  output logic [31:0]        pc_plus4,
  output logic               fault,
  output logic [31:0]        fault_pc
);

  fetch_state_t state, next_state;
  logic [31:0]  pc;
  logic         pc_load;
  logic         pc_load_redirect;
  logic         capture;
  logic         fault_set;
  logic         unused_pc_bits;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_en        (pc_load),
    .load_redirect  (pc_load_redirect),
    .redirect_target(redirect_target),
    .pc             (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A redirect outranks both ack and stall; FAULT ignores everything but reset.
  always_comb begin
    next_state       = state;
    pc_load          = 1'b0;
    pc_load_redirect = 1'b0;
    capture          = 1'b0;
    fault_set        = 1'b0;
    if (state != FAULT && redirect_valid) begin
      if (is_word_aligned(redirect_target)) begin
        pc_load          = 1'b1;
        pc_load_redirect = 1'b1;
        next_state       = FETCH;
      end else begin
        fault_set  = 1'b1;
        next_state = FAULT;
      end
    end else begin
      case (state)
        IDLE:  next_state = FETCH;
        FETCH: begin
          if (imem_ack) begin
            capture    = 1'b1;
            next_state = VALID;
          end
        end
        VALID: begin
          if (!stall) begin
            pc_load    = 1'b1;
            next_state = FETCH;
          end
        end
        FAULT:   next_state = FAULT;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr    <= 32'h0;
      instr_pc <= 32'h0;
    end else if (capture) begin
      instr    <= imem_rdata;
      instr_pc <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault    <= 1'b0;
      fault_pc <= 32'h0;
    end else if (fault_set) begin
      fault    <= 1'b1;
      fault_pc <= redirect_target;
    end
  end

  // Memory-facing outputs depend only on registered state and PC.
  assign imem_req       = (state == FETCH);
  assign instr_valid    = (state == VALID);
  assign imem_word_addr = pc[IMEM_AW+1:2];
  assign pc_plus4       = instr_pc + WORD_BYTES;
  assign unused_pc_bits = ^{pc[31:IMEM_AW+2], pc[1:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a zero-wait memory
// model returning word_addr*16.
module tb_instr_fetch_unit;

  localparam int IMEM_AW = 10;

  logic               clk;
  logic               rst_n;
  logic               stall;
  logic               redirect_valid;
  logic [31:0]        redirect_target;
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_word_addr;
  logic               imem_ack;
  logic [31:0]        imem_rdata;
  logic               instr_valid;
  logic [31:0]        instr;
  logic [31:0]        instr_pc;
  logic [31:0]        pc_plus4;
  logic               fault;
  logic [31:0]        fault_pc;

  logic ack_auto;
  logic ack_force;
  int   check_count;
  int   pass_count;

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .IMEM_AW (IMEM_AW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_word_addr (imem_word_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc_plus4       (pc_plus4),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait memory acks every request unless the bench takes manual control.
  assign imem_ack   = ack_auto ? imem_req : ack_force;
  assign imem_rdata = {18'h0, imem_word_addr, 4'h0};

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    check_count     = 0;
    pass_count      = 0;
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    ack_auto        = 1'b1;
    ack_force       = 1'b0;

    applyStimulus();
    applyStimulus();
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_instr_pc", instr_pc, 32'h0);
    checkOutput("rst_pc_plus4", pc_plus4, 32'h4);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_fault_pc", fault_pc, 32'h0);
    rst_n = 1'b1;

    // Sequential fetch: FETCH/VALID alternate with zero-wait memory.
    applyStimulus();
    checkOutput("c2_req", 32'(imem_req), 32'd1);
    checkOutput("c2_addr", 32'(imem_word_addr), 32'd0);
    applyStimulus();
    checkOutput("c3_valid", 32'(instr_valid), 32'd1);
    checkOutput("c3_instr_pc", instr_pc, 32'h0);
    checkOutput("c3_instr", instr, 32'h0);
    applyStimulus();
    checkOutput("c4_addr", 32'(imem_word_addr), 32'd1);
    checkOutput("c4_valid", 32'(instr_valid), 32'd0);
    applyStimulus();
    checkOutput("c5_valid", 32'(instr_valid), 32'd1);
    checkOutput("c5_instr_pc", instr_pc, 32'h4);
    checkOutput("c5_instr", instr, 32'h10);
    applyStimulus();
    checkOutput("c6_addr", 32'(imem_word_addr), 32'd2);
    stall = 1'b1;
    applyStimulus();
    checkOutput("c7_valid", 32'(instr_valid), 32'd1);
    checkOutput("c7_instr_pc", instr_pc, 32'h8);
    checkOutput("c7_instr", instr, 32'h20);

    // Stall holds the delivered instruction and suppresses requests.
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("stall_valid", 32'(instr_valid), 32'd1);
      checkOutput("stall_instr_pc", instr_pc, 32'h8);
      checkOutput("stall_instr", instr, 32'h20);
      checkOutput("stall_req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    applyStimulus();
    checkOutput("unstall_req", 32'(imem_req), 32'd1);
    checkOutput("unstall_addr", 32'(imem_word_addr), 32'd3);

    // Redirect coincident with ack: the returned word must be discarded.
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    applyStimulus();
    redirect_valid = 1'b0;
    checkOutput("redir_addr", 32'(imem_word_addr), 32'd16);
    checkOutput("redir_valid", 32'(instr_valid), 32'd0);
    checkOutput("redir_instr_pc_held", instr_pc, 32'h8);
    applyStimulus();
    checkOutput("redir_instr_pc", instr_pc, 32'h40);
    checkOutput("redir_instr", instr, 32'h100);

    // Redirect to the last word of the address space, then wrap.
    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    applyStimulus();
    redirect_valid = 1'b0;
    checkOutput("top_addr", 32'(imem_word_addr), 32'h3FF);
    applyStimulus();
    checkOutput("top_instr_pc", instr_pc, 32'hFFFF_FFFC);
    checkOutput("top_pc_plus4", pc_plus4, 32'h0);
    checkOutput("top_instr", instr, 32'h3FF0);
    checkOutput("top_fault", 32'(fault), 32'd0);
    stall = 1'b0;
    applyStimulus();
    checkOutput("wrap_addr", 32'(imem_word_addr), 32'd0);
    checkOutput("wrap_fault", 32'(fault), 32'd0);
    applyStimulus();
    checkOutput("wrap_instr_pc", instr_pc, 32'h0);

    // Misaligned redirect traps; a later aligned redirect must not escape.
    redirect_valid  = 1'b1;
    redirect_target = 32'h42;
    applyStimulus();
    checkOutput("fault_flag", 32'(fault), 32'd1);
    checkOutput("fault_pc", fault_pc, 32'h42);
    checkOutput("fault_req", 32'(imem_req), 32'd0);
    checkOutput("fault_valid", 32'(instr_valid), 32'd0);
    redirect_target = 32'h80;
    applyStimulus();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("fault_sticky", 32'(fault), 32'd1);
      checkOutput("fault_sticky_pc", fault_pc, 32'h42);
      checkOutput("fault_sticky_req", 32'(imem_req), 32'd0);
    end
    rst_n = 1'b0;
    applyStimulus();
    checkOutput("fault_clr", 32'(fault), 32'd0);
    checkOutput("fault_clr_pc", fault_pc, 32'h0);
    checkOutput("fault_clr_instr_pc", instr_pc, 32'h0);
    checkOutput("fault_clr_pc_plus4", pc_plus4, 32'h4);

    // Slow memory: reset during the wait, then a late ack must be ignored.
    rst_n    = 1'b1;
    ack_auto = 1'b0;
    applyStimulus();
    checkOutput("slow_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("slow_wait_valid", 32'(instr_valid), 32'd0);
      checkOutput("slow_wait_req", 32'(imem_req), 32'd1);
    end
    rst_n = 1'b0;
    applyStimulus();
    checkOutput("slow_rst_req", 32'(imem_req), 32'd0);
    checkOutput("slow_rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("slow_rst_instr_pc", instr_pc, 32'h0);
    checkOutput("slow_rst_addr", 32'(imem_word_addr), 32'd0);
    rst_n     = 1'b1;
    ack_force = 1'b1;
    applyStimulus();
    ack_force = 1'b0;
    checkOutput("late_ack_valid", 32'(instr_valid), 32'd0);
    checkOutput("late_ack_req", 32'(imem_req), 32'd1);
    applyStimulus();
    checkOutput("late_ack_valid2", 32'(instr_valid), 32'd0);
    checkOutput("late_ack_instr", instr, 32'h0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
